dit_timing_miter: RTL and testbench
===================================

DIT_TIMING_MITER -- requirements
Module: dit_timing_miter

Interface
REQ-001 Parameter NUM_CH, default 1: number of functional-unit channel pairs monitored.
REQ-002 Parameter CNT_W, default 16: width of cycle counter and reported cycle stamp.
REQ-003 Parameter OUTST_W, default 4: width of per-copy outstanding-operation counters; maximum outstanding is 2^OUTST_W-1.
REQ-004 Parameter WDOG_LIMIT, default 64: watchdog idle-cycle limit, used only with DIT_MITER_WDOG_EN.
REQ-005 clock  input  1  single clock, all state on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 arm  input  1  start monitoring; sampled in IDLE.
REQ-008 clear  input  1  synchronous return to IDLE, clears all sticky state.
REQ-009 io_validin  input  NUM_CH  shared issue strobe driven into both copies.
REQ-010 u1_validout  input  NUM_CH  completion strobes of copy 1.
REQ-011 u2_validout  input  NUM_CH  completion strobes of copy 2.
REQ-012 mismatch  output  1  sticky: completion timing of the copies diverged.
REQ-013 mismatch_ch  output  $clog2(NUM_CH)+1  channel of first divergence.
REQ-014 mismatch_cycle  output  CNT_W  cycle stamp of first divergence.
REQ-015 proto_err  output  1  sticky: outstanding counter overflow or underflow.
REQ-016 state  output  2  FSM state encoding.
REQ-017 hang  output  1  sticky watchdog flag (constant 0 without the macro).

Function
REQ-018 FSM states SHALL be IDLE=0, ARMED=1, TRACK=2, DIVERGED=3.
REQ-019 IDLE->ARMED when arm=1; ARMED->TRACK on the first cycle with any io_validin bit set; TRACK->DIVERGED on mismatch detection; DIVERGED SHALL hold until clear.
REQ-020 clear=1 SHALL force IDLE next cycle from any state and zero all counters and sticky outputs; clear has priority over all other events.
REQ-021 Cycle counter SHALL reset to 0 on entering ARMED, increment each cycle in ARMED/TRACK, saturate at all-ones, and freeze in DIVERGED.
REQ-022 In ARMED/TRACK, per channel and copy, the outstanding counter SHALL increment on io_validin, decrement on that copy's validout, and stay unchanged when both occur in the same cycle.
REQ-023 In TRACK, u1_validout[i] != u2_validout[i] in any cycle SHALL set mismatch on the next edge, recording i and the current cycle count.
REQ-024 Simultaneous mismatches on several channels SHALL record the lowest index.
REQ-025 A validout with that copy's counter at 0 (and no same-cycle issue), or an issue with the counter at maximum (and no same-cycle validout), SHALL set proto_err; the counter SHALL saturate rather than wrap.
REQ-026 proto_err SHALL NOT change FSM state.
REQ-027 In IDLE all strobes SHALL be ignored.

Reset
REQ-028 Asynchronous reset SHALL force state=IDLE and all counters, mismatch, mismatch_ch, mismatch_cycle, proto_err and hang to 0.
REQ-029 Reset asserted mid-TRACK SHALL discard all outstanding counts; no flag SHALL survive reset.

Configuration
REQ-030 Macro DIT_MITER_WDOG_EN defined: in TRACK, if any counter is nonzero and no validout bit on either copy is seen for WDOG_LIMIT consecutive cycles, hang SHALL set (sticky, cleared by clear/reset).
REQ-031 Macro undefined: no watchdog logic; hang tied to 0.

Structure
REQ-032 Package dit_miter_pkg SHALL hold the state enum type and state encodings.
REQ-033 Sub-module dit_outst_ctr SHALL implement one saturating outstanding counter with overflow/underflow outputs, instantiated 2*NUM_CH times.

Verification
REQ-034 arm, then issue ch0 at cycle 2; both copies validout at cycle 6 -> mismatch=0, state=TRACK, counters 0.
REQ-035 NUM_CH=2: u1_validout[1] at cycle 7, u2_validout[1] at cycle 8 -> mismatch=1, mismatch_ch=1, mismatch_cycle=stamp of cycle 7, state=DIVERGED.
REQ-036 Mismatch on ch0 and ch1 in the same cycle -> mismatch_ch=0.
REQ-037 u1_validout with no outstanding op -> proto_err=1, counter stays 0, state unchanged.
REQ-038 Reset asserted in DIVERGED, and separately clear=1 -> all outputs 0, state=IDLE; with DIT_MITER_WDOG_EN, WDOG_LIMIT=8, one issue and no completions -> hang=1 after 8 cycles.

Source files
------------

// File: rtl/dit_miter_pkg.sv
// Shared types for the dual-copy timing miter: FSM state encoding.
package dit_miter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ARMED    = 2'd1,
    ST_TRACK    = 2'd2,
    ST_DIVERGED = 2'd3
  } miter_state_e;

endpackage

// File: rtl/dit_outst_ctr.sv
// One saturating outstanding-operation counter for a single channel of one
// functional-unit copy. Overflow/underflow flags are combinational for the
// current cycle; the count never wraps.
module dit_outst_ctr
  import dit_miter_pkg::*;
#(
  parameter int OUTST_W = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  input  logic i_inc,
  input  logic i_dec,
  output logic o_busy,
  output logic o_ovf,
  output logic o_unf
);

  logic [OUTST_W-1:0] r_cnt;
  logic               w_full;
  logic               w_empty;

  assign w_full  = &r_cnt;
  assign w_empty = (r_cnt == '0);
  assign o_busy  = ~w_empty;
  assign o_ovf   = i_en & i_inc & ~i_dec & w_full;
  assign o_unf   = i_en & i_dec & ~i_inc & w_empty;

  // Count issues up and completions down, holding at both rails.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      if (i_inc && !i_dec && !w_full) begin
        r_cnt <= r_cnt + OUTST_W'(1);
      end else if (i_dec && !i_inc && !w_empty) begin
        r_cnt <= r_cnt - OUTST_W'(1);
      end
    end
  end

endmodule

// File: rtl/dit_timing_miter.sv
// Timing miter comparing completion strobes of two copies of a functional
// unit fed from a shared issue strobe. Records the first divergence
// (channel and cycle stamp) and flags outstanding-count protocol errors.
// Optional idle watchdog enabled by defining DIT_MITER_WDOG_EN.
module dit_timing_miter
  import dit_miter_pkg::*;
#(
  parameter int NUM_CH     = 1,
  parameter int CNT_W      = 16,
  parameter int OUTST_W    = 4,
  parameter int WDOG_LIMIT = 64
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      arm,
  input  logic                      clear,
  input  logic [NUM_CH-1:0]         io_validin,
  input  logic [NUM_CH-1:0]         u1_validout,
  input  logic [NUM_CH-1:0]         u2_validout,
  output logic                      mismatch,
  output logic [$clog2(NUM_CH):0]   mismatch_ch,
  output logic [CNT_W-1:0]          mismatch_cycle,
  output logic                      proto_err,
  output logic [1:0]                state,
  output logic                      hang
);

  localparam int MCH_W = $clog2(NUM_CH) + 1;

  miter_state_e       r_state;
  logic [CNT_W-1:0]   r_cyc;
  logic               r_mm;
  logic [MCH_W-1:0]   r_mm_ch;
  logic [CNT_W-1:0]   r_mm_cyc;
  logic               r_perr;

  logic               w_active;
  logic [NUM_CH-1:0]  w_busy1, w_busy2;
  logic [NUM_CH-1:0]  w_ovf1, w_ovf2, w_unf1, w_unf2;
  logic               w_perr;
  logic [NUM_CH-1:0]  w_diff;
  logic [MCH_W-1:0]   w_mm_idx;

  assign w_active = (r_state == ST_ARMED) || (r_state == ST_TRACK);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    dit_outst_ctr #(.OUTST_W(OUTST_W)) u_ctr1 (
      .i_clk  (clock),
      .i_rst  (reset),
      .i_clr  (clear),
      .i_en   (w_active),
      .i_inc  (io_validin[g]),
      .i_dec  (u1_validout[g]),
      .o_busy (w_busy1[g]),
      .o_ovf  (w_ovf1[g]),
      .o_unf  (w_unf1[g])
    );
    dit_outst_ctr #(.OUTST_W(OUTST_W)) u_ctr2 (
      .i_clk  (clock),
      .i_rst  (reset),
      .i_clr  (clear),
      .i_en   (w_active),
      .i_inc  (io_validin[g]),
      .i_dec  (u2_validout[g]),
      .o_busy (w_busy2[g]),
      .o_ovf  (w_ovf2[g]),
      .o_unf  (w_unf2[g])
    );
  end

  // Counters are only enabled in ARMED/TRACK, so their flags are pre-gated.
  assign w_perr = |{w_ovf1, w_ovf2, w_unf1, w_unf2};
  assign w_diff = u1_validout ^ u2_validout;

  // Lowest diverging channel wins; scan downward so the last hit is lowest.
  always_comb begin
    w_mm_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (w_diff[i]) w_mm_idx = MCH_W'(i);
    end
  end

  // Miter FSM with cycle stamp and sticky divergence/protocol flags.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_cyc    <= '0;
      r_mm     <= 1'b0;
      r_mm_ch  <= '0;
      r_mm_cyc <= '0;
      r_perr   <= 1'b0;
    end else if (clear) begin
      r_state  <= ST_IDLE;
      r_cyc    <= '0;
      r_mm     <= 1'b0;
      r_mm_ch  <= '0;
      r_mm_cyc <= '0;
      r_perr   <= 1'b0;
    end else begin
      if (w_perr) r_perr <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (arm) begin
            r_state <= ST_ARMED;
            r_cyc   <= '0;
          end
        end
        ST_ARMED: begin
          if (r_cyc != '1) r_cyc <= r_cyc + CNT_W'(1);
          if (|io_validin) r_state <= ST_TRACK;
        end
        ST_TRACK: begin
          if (r_cyc != '1) r_cyc <= r_cyc + CNT_W'(1);
          if (|w_diff) begin
            r_state  <= ST_DIVERGED;
            r_mm     <= 1'b1;
            r_mm_ch  <= w_mm_idx;
            r_mm_cyc <= r_cyc;
          end
        end
        default: ;
      endcase
    end
  end

  assign state          = r_state;
  assign mismatch       = r_mm;
  assign mismatch_ch    = r_mm_ch;
  assign mismatch_cycle = r_mm_cyc;
  assign proto_err      = r_perr;

`ifdef DIT_MITER_WDOG_EN
  localparam int WD_W = $clog2(WDOG_LIMIT + 1);

  logic [WD_W-1:0] r_idle;
  logic            r_hang;
  logic            w_wd_tick;

  assign w_wd_tick = (r_state == ST_TRACK) && (|{w_busy1, w_busy2}) &&
                     !(|{u1_validout, u2_validout});

  // Count consecutive quiet cycles with work outstanding; latch hang at limit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_idle <= '0;
      r_hang <= 1'b0;
    end else if (clear) begin
      r_idle <= '0;
      r_hang <= 1'b0;
    end else if (w_wd_tick) begin
      if (r_idle == WD_W'(WDOG_LIMIT - 1)) r_hang <= 1'b1;
      if (r_idle != WD_W'(WDOG_LIMIT)) r_idle <= r_idle + WD_W'(1);
    end else begin
      r_idle <= '0;
    end
  end

  assign hang = r_hang;
`else
  logic w_unused_wdog;
  assign w_unused_wdog = |{w_busy1, w_busy2, WDOG_LIMIT[0]};
  assign hang = 1'b0;
`endif

endmodule

// File: tb/tb_dit_timing_miter.sv
// Self-checking bench for dit_timing_miter: directed scenarios plus a
// randomized run against an integer-level reference model.
module tb_dit_timing_miter;

  localparam int NCH  = 2;
  localparam int CW   = 16;
  localparam int OW   = 2;
  localparam int WDL  = 8;
  localparam int OMAX = (1 << OW) - 1;
  localparam int CMAX = (1 << CW) - 1;

`ifdef DIT_MITER_WDOG_EN
  localparam logic HANG_ON = 1'b1;
`else
  localparam logic HANG_ON = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst, arm, clear;
  logic [NCH-1:0] vin, o1, o2;
  logic           mm, perr, hang;
  logic [1:0]     mch;
  logic [CW-1:0]  mcyc;
  logic [1:0]     st;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: 0 idle, 1 armed, 2 tracking, 3 diverged
  int   m_state, m_cyc, m_mmch, m_mmcyc, m_idle;
  int   m_c1 [NCH];
  int   m_c2 [NCH];
  logic m_mm, m_perr, m_hang;

  dit_timing_miter #(.NUM_CH(NCH), .CNT_W(CW), .OUTST_W(OW), .WDOG_LIMIT(WDL)) dut (
    .clock          (clk),
    .reset          (rst),
    .arm            (arm),
    .clear          (clear),
    .io_validin     (vin),
    .u1_validout    (o1),
    .u2_validout    (o2),
    .mismatch       (mm),
    .mismatch_ch    (mch),
    .mismatch_cycle (mcyc),
    .proto_err      (perr),
    .state          (st),
    .hang           (hang)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_state = 0; m_cyc = 0; m_mmch = 0; m_mmcyc = 0; m_idle = 0;
    m_mm = 1'b0; m_perr = 1'b0; m_hang = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      m_c1[i] = 0;
      m_c2[i] = 0;
    end
  endfunction

  function automatic int upd(input int n, input logic inc, input logic dec);
    if (inc && !dec) begin
      if (n == OMAX) begin m_perr = 1'b1; return n; end
      return n + 1;
    end
    if (dec && !inc) begin
      if (n == 0) begin m_perr = 1'b1; return 0; end
      return n - 1;
    end
    return n;
  endfunction

  function automatic void model_step(input logic a, input logic c,
                                     input logic [NCH-1:0] v, input logic [NCH-1:0] p,
                                     input logic [NCH-1:0] q);
    int first;
    bit busy;
    if (c) begin model_reset(); return; end
    if (m_state == 0) begin
      if (a) begin m_state = 1; m_cyc = 0; end
      return;
    end
    if (m_state == 3) return;
    first = -1;
    if (m_state == 2)
      for (int i = NCH - 1; i >= 0; i--) if (p[i] != q[i]) first = i;
    busy = 0;
    for (int i = 0; i < NCH; i++) if (m_c1[i] != 0 || m_c2[i] != 0) busy = 1;
`ifdef DIT_MITER_WDOG_EN
    if (m_state == 2 && busy && p == '0 && q == '0) begin
      m_idle++;
      if (m_idle >= WDL) m_hang = 1'b1;
    end else m_idle = 0;
`endif
    for (int i = 0; i < NCH; i++) begin
      m_c1[i] = upd(m_c1[i], v[i], p[i]);
      m_c2[i] = upd(m_c2[i], v[i], q[i]);
    end
    if (first >= 0) begin
      m_mm = 1'b1; m_mmch = first; m_mmcyc = m_cyc; m_state = 3;
    end else if (m_state == 1 && v != '0) m_state = 2;
    if (m_cyc < CMAX) m_cyc++;
  endfunction

  task automatic step(input logic a, input logic c, input logic [NCH-1:0] v,
                      input logic [NCH-1:0] p, input logic [NCH-1:0] q);
    arm = a; clear = c; vin = v; o1 = p; o2 = q;
    model_step(a, c, v, p, q);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; arm = 1'b0; clear = 1'b0; vin = '0; o1 = '0; o2 = '0;
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    #2;
    n_tests++;
    if ({st, mm, mch, mcyc, perr, hang} !== '0) begin
      n_fail++;
      $display("FAIL reset_async: st=%0d mm=%0b ch=%0d cyc=%0d perr=%0b hang=%0b, want all 0",
               st, mm, mch, mcyc, perr, hang);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    n_tests++;
    if (st !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", st); end
  endtask

  task automatic test_match();
    do_reset();
    step(1, 0, 2'b00, 2'b00, 2'b00);
    n_tests++;
    if (st !== 2'd1) begin n_fail++; $display("FAIL arm_state: got %0d want 1", st); end
    step(0, 0, 2'b00, 2'b00, 2'b00);
    step(0, 0, 2'b01, 2'b00, 2'b00);
    n_tests++;
    if (st !== 2'd2) begin n_fail++; $display("FAIL issue_track: got %0d want 2", st); end
    repeat (3) step(0, 0, 2'b00, 2'b00, 2'b00);
    step(0, 0, 2'b00, 2'b01, 2'b01);
    n_tests++;
    if ({st, mm, perr} !== {2'd2, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL match_ok: st=%0d mm=%0b perr=%0b want st=2 mm=0 perr=0", st, mm, perr);
    end
    step(0, 0, 2'b00, 2'b01, 2'b01);
    n_tests++;
    if ({st, mm, perr} !== {2'd2, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL cnt_zero_after_done: st=%0d mm=%0b perr=%0b want st=2 mm=0 perr=1", st, mm, perr);
    end
  endtask

  task automatic test_proto();
    do_reset();
    step(1, 0, 2'b00, 2'b00, 2'b00);
    step(0, 0, 2'b00, 2'b01, 2'b00);
    n_tests++;
    if ({st, mm, perr} !== {2'd1, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL underflow: st=%0d mm=%0b perr=%0b want st=1 mm=0 perr=1", st, mm, perr);
    end
    do_reset();
    step(1, 0, 2'b00, 2'b00, 2'b00);
    repeat (OMAX) step(0, 0, 2'b01, 2'b00, 2'b00);
    n_tests++;
    if (perr !== 1'b0) begin n_fail++; $display("FAIL at_max_no_err: got %0b want 0", perr); end
    step(0, 0, 2'b01, 2'b00, 2'b00);
    n_tests++;
    if ({st, perr} !== {2'd2, 1'b1}) begin
      n_fail++;
      $display("FAIL overflow: st=%0d perr=%0b want st=2 perr=1", st, perr);
    end
  endtask

  task automatic test_diverge();
    do_reset();
    step(1, 0, 2'b00, 2'b00, 2'b00);
    step(0, 0, 2'b10, 2'b00, 2'b00);
    repeat (4) step(0, 0, 2'b00, 2'b00, 2'b00);
    step(0, 0, 2'b00, 2'b10, 2'b00);
    n_tests++;
    if ({st, mm, mch, mcyc} !== {2'd3, 1'b1, 2'd1, CW'(5)}) begin
      n_fail++;
      $display("FAIL diverge_ch1: st=%0d mm=%0b ch=%0d cyc=%0d want st=3 mm=1 ch=1 cyc=5",
               st, mm, mch, mcyc);
    end
    step(1, 0, 2'b11, 2'b00, 2'b10);
    n_tests++;
    if ({st, mm, mch, mcyc} !== {2'd3, 1'b1, 2'd1, CW'(m_mmcyc)}) begin
      n_fail++;
      $display("FAIL diverged_hold: st=%0d ch=%0d cyc=%0d want st=3 ch=1 cyc=%0d", st, mch, mcyc, m_mmcyc);
    end
  endtask

  task automatic test_simul_and_clear();
    do_reset();
    step(1, 0, 2'b00, 2'b00, 2'b00);
    step(0, 0, 2'b11, 2'b00, 2'b00);
    step(0, 0, 2'b00, 2'b11, 2'b00);
    n_tests++;
    if ({st, mm, mch} !== {2'd3, 1'b1, 2'd0}) begin
      n_fail++;
      $display("FAIL simul_lowest: st=%0d mm=%0b ch=%0d want st=3 mm=1 ch=0", st, mm, mch);
    end
    step(1, 1, 2'b11, 2'b01, 2'b10);
    n_tests++;
    if ({st, mm, mch, mcyc, perr, hang} !== '0) begin
      n_fail++;
      $display("FAIL clear_all: st=%0d mm=%0b ch=%0d cyc=%0d perr=%0b hang=%0b want all 0",
               st, mm, mch, mcyc, perr, hang);
    end
    step(0, 0, 2'b11, 2'b01, 2'b10);
    n_tests++;
    if ({st, mm, perr} !== '0) begin
      n_fail++;
      $display("FAIL idle_ignore: st=%0d mm=%0b perr=%0b want 0", st, mm, perr);
    end
  endtask

  task automatic test_track_reset();
    do_reset();
    step(1, 0, 2'b00, 2'b00, 2'b00);
    step(0, 0, 2'b01, 2'b00, 2'b00);
    step(0, 0, 2'b00, 2'b00, 2'b00);
    do_reset();
    step(1, 0, 2'b00, 2'b00, 2'b00);
    step(0, 0, 2'b10, 2'b00, 2'b00);
    step(0, 0, 2'b00, 2'b01, 2'b01);
    n_tests++;
    if ({st, mm, perr} !== {2'd2, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_discards_cnt: st=%0d mm=%0b perr=%0b want st=2 mm=0 perr=1", st, mm, perr);
    end
  endtask

  task automatic test_hang();
    do_reset();
    step(1, 0, 2'b00, 2'b00, 2'b00);
    step(0, 0, 2'b01, 2'b00, 2'b00);
    repeat (WDL - 1) step(0, 0, 2'b00, 2'b00, 2'b00);
    n_tests++;
    if (hang !== 1'b0) begin n_fail++; $display("FAIL hang_early: got %0b want 0", hang); end
    step(0, 0, 2'b00, 2'b00, 2'b00);
    n_tests++;
    if (hang !== HANG_ON) begin n_fail++; $display("FAIL hang_limit: got %0b want %0b", hang, HANG_ON); end
    step(0, 1, 2'b00, 2'b00, 2'b00);
    n_tests++;
    if (hang !== 1'b0) begin n_fail++; $display("FAIL hang_clear: got %0b want 0", hang); end
  endtask

  task automatic test_random();
    logic           a, c;
    logic [NCH-1:0] v, p, q;
    int             k;
    for (int r = 0; r < 4; r++) begin
      do_reset();
      for (int n = 0; n < 250; n++) begin
        a = ($urandom_range(0, 3) == 0);
        c = ($urandom_range(0, 59) == 0);
        v = '0;
        p = '0;
        for (int i = 0; i < NCH; i++) begin
          v[i] = ($urandom_range(0, 3) == 0);
          p[i] = (m_c1[i] > 0) && ($urandom_range(0, 2) == 0);
          if ($urandom_range(0, 99) == 0) p[i] = ~p[i];
        end
        q = p;
        if ($urandom_range(0, 59) == 0) begin
          k = $urandom_range(0, NCH - 1);
          q[k] = ~q[k];
        end
        step(a, c, v, p, q);
        n_tests++;
        if ({st, mm, mch, mcyc, perr, hang} !==
            {m_state[1:0], m_mm, m_mmch[1:0], m_mmcyc[CW-1:0], m_perr, m_hang}) begin
          n_fail++;
          $display("FAIL random r%0d n%0d: got st=%0d mm=%0b ch=%0d cyc=%0d perr=%0b hang=%0b want st=%0d mm=%0b ch=%0d cyc=%0d perr=%0b hang=%0b",
                   r, n, st, mm, mch, mcyc, perr, hang,
                   m_state, m_mm, m_mmch, m_mmcyc, m_perr, m_hang);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b0; arm = 1'b0; clear = 1'b0; vin = '0; o1 = '0; o2 = '0;
    model_reset();
    test_reset();
    test_match();
    test_proto();
    test_diverge();
    test_reset();
    test_simul_and_clear();
    test_track_reset();
    test_hang();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
